// File: rtl/execute_hazard_ctrl.sv
// rtl/execute_hazard_ctrl.sv - Execute/DMEM pipeline sequencer: interlocks, memory waits, redirect flush
module execute_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_we,
  input  logic             ex_is_load,
  input  logic             do_jump,
  input  logic             mem_req_valid,
  input  logic             mem_req_is_load,
  input  logic             mem_req_ready,
  input  logic             mem_resp_valid,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             redirect,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    REQ_WAIT  = 2'd1,
    RESP_WAIT = 2'd2,
    REDIRECT  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  state_t     eff_st, post_st;
  logic       ret_q, ret_d;
  logic [2:0] cnt_q, cnt_d;
  logic       freeze, load_use, acc_load;

  assign load_use = ex_is_load && ex_reg_we && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign acc_load = mem_req_valid && mem_req_ready && mem_req_is_load;

  // A completing wait state behaves like the state it will return to.
  assign eff_st = ((state_q == REQ_WAIT) || (state_q == RESP_WAIT)) ?
                  (ret_q ? REDIRECT : RUN) : state_q;

  assign freeze = ((state_q == RESP_WAIT) && !mem_resp_valid) ||
                  ((state_q == REQ_WAIT) && !mem_req_ready) ||
                  ((state_q != REQ_WAIT) && mem_req_valid && !mem_req_ready);

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    redirect  = 1'b0;
    post_st   = eff_st;
    cnt_d     = cnt_q;
    ret_d     = ret_q;
    state_d   = state_q;
    if (freeze) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      ret_d     = (eff_st == REDIRECT);
      state_d   = ((state_q == RESP_WAIT) && !mem_resp_valid) ? RESP_WAIT : REQ_WAIT;
    end else begin
      if (eff_st == REDIRECT) begin
        flush_id = 1'b1;
        cnt_d    = cnt_q - 3'd1;
        if (cnt_q == 3'd1) post_st = RUN;
      end else if (do_jump) begin
        redirect = 1'b1;
        flush_id = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          post_st = REDIRECT;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
        end
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      // An accepted load parks in RESP_WAIT, remembering where to resume.
      if (acc_load) begin
        state_d = RESP_WAIT;
        ret_d   = (post_st == REDIRECT);
      end else begin
        state_d = post_st;
        ret_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ret_q       <= 1'b0;
      cnt_q       <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      stall_count <= stall_count + CNT_W'(stall_if);
      flush_count <= flush_count + CNT_W'(flush_id);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_execute_hazard_ctrl.sv
// tb/tb_execute_hazard_ctrl.sv - directed self-checking bench for execute_hazard_ctrl
module tb_execute_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_reg_we, ex_is_load, do_jump;
  logic        mem_req_valid, mem_req_is_load, mem_req_ready, mem_resp_valid;
  logic        stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_id, redirect;
  logic [1:0]  state_o;
  logic [31:0] stall_count, flush_count;
  logic [6:0]  outs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  execute_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .do_jump(do_jump),
    .mem_req_valid(mem_req_valid), .mem_req_is_load(mem_req_is_load),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .redirect(redirect),
    .state_o(state_o), .stall_count(stall_count), .flush_count(flush_count)
  );

  // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_id, redirect}
  assign outs = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_id, redirect};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_reg_we = 0; ex_is_load = 0; do_jump = 0;
    mem_req_valid = 0; mem_req_is_load = 0; mem_req_ready = 1; mem_resp_valid = 0;
  endtask

  // Advance to the next falling edge, then let combinational outputs settle.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step(); step();
    settle();
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_stall_cnt", stall_count, 32'd0);
    check("reset_flush_cnt", flush_count, 32'd0);
    rst_n = 1'b1;

    // Load-use on rs2
    step(); ex_is_load = 1; ex_reg_we = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1; settle();
    check("lu_rs2_outs", 32'(outs), 32'b1100100);
    step(); idle(); settle();
    check("lu_after_outs", 32'(outs), 32'd0);
    // ex_rd = 0 never interlocks
    step(); ex_is_load = 1; ex_reg_we = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1; settle();
    check("lu_x0_outs", 32'(outs), 32'd0);
    // Match on rs1 but the operand is unused
    step(); idle(); ex_is_load = 1; ex_reg_we = 1; ex_rd = 9; id_rs1 = 9; settle();
    check("lu_unused_outs", 32'(outs), 32'd0);
    id_uses_rs1 = 1; settle();
    check("lu_rs1_outs", 32'(outs), 32'b1100100);
    step(); idle(); settle();
    check("lu_stall_cnt", stall_count, 32'd2);

    // Jump in RUN: two flush cycles
    do_jump = 1; settle();
    check("jmp_c0_outs", 32'(outs), 32'b0000011);
    step(); do_jump = 0; settle();
    check("jmp_c1_state", 32'(state_o), 32'd3);
    check("jmp_c1_outs", 32'(outs), 32'b0000010);
    step(); settle();
    check("jmp_c2_state", 32'(state_o), 32'd0);
    check("jmp_c2_outs", 32'(outs), 32'd0);
    check("jmp_flush_cnt", flush_count, 32'd2);

    // Jump beats load-use
    ex_is_load = 1; ex_reg_we = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; do_jump = 1; settle();
    check("jmp_lu_outs", 32'(outs), 32'b0000011);
    step(); idle(); settle();
    check("jmp_lu_c1_outs", 32'(outs), 32'b0000010);
    step(); settle();
    check("jmp_lu_c2_state", 32'(state_o), 32'd0);

    // Store blocked for three cycles
    mem_req_valid = 1; mem_req_is_load = 0; mem_req_ready = 0; settle();
    check("st_w0_outs", 32'(outs), 32'b1111000);
    step(); settle();
    check("st_w1_state", 32'(state_o), 32'd1);
    check("st_w1_outs", 32'(outs), 32'b1111000);
    step(); settle();
    check("st_w2_outs", 32'(outs), 32'b1111000);
    step(); mem_req_ready = 1; settle();
    check("st_rdy_outs", 32'(outs), 32'd0);
    step(); idle(); settle();
    check("st_done_state", 32'(state_o), 32'd0);
    check("st_stall_cnt", stall_count, 32'd5);

    // Load accepted, response two cycles late, jump waiting in EX
    mem_req_valid = 1; mem_req_is_load = 1; mem_req_ready = 1; settle();
    check("ld_acc_outs", 32'(outs), 32'd0);
    step(); idle(); do_jump = 1; settle();
    check("ld_w0_state", 32'(state_o), 32'd2);
    check("ld_w0_outs", 32'(outs), 32'b1111000);
    step(); settle();
    check("ld_w1_outs", 32'(outs), 32'b1111000);
    step(); mem_resp_valid = 1; settle();
    check("ld_resp_outs", 32'(outs), 32'b0000011);
    step(); idle(); settle();
    check("ld_redir_state", 32'(state_o), 32'd3);
    check("ld_redir_outs", 32'(outs), 32'b0000010);
    step(); settle();
    check("ld_end_state", 32'(state_o), 32'd0);
    check("ld_stall_cnt", stall_count, 32'd7);
    check("ld_flush_cnt", flush_count, 32'd6);

    // Freeze during REDIRECT keeps the flush counter
    do_jump = 1; settle();
    step(); do_jump = 0; mem_req_valid = 1; mem_req_is_load = 0; mem_req_ready = 0; settle();
    check("rf_frz_outs", 32'(outs), 32'b1111000);
    step(); mem_req_ready = 1; settle();
    check("rf_rdy_state", 32'(state_o), 32'd1);
    check("rf_rdy_outs", 32'(outs), 32'b0000010);
    step(); idle(); settle();
    check("rf_end_state", 32'(state_o), 32'd0);
    check("rf_end_outs", 32'(outs), 32'd0);
    check("rf_stall_cnt", stall_count, 32'd8);
    check("rf_flush_cnt", flush_count, 32'd8);

    // Asynchronous reset while in REDIRECT with counter at 1
    do_jump = 1; settle();
    step(); do_jump = 0; settle();
    check("ar_pre_state", 32'(state_o), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("ar_state", 32'(state_o), 32'd0);
    check("ar_stall_cnt", stall_count, 32'd0);
    check("ar_flush_cnt", flush_count, 32'd0);
    step(); rst_n = 1'b1;
    step(); settle();
    check("ar_post_outs", 32'(outs), 32'd0);
    check("ar_post_state", 32'(state_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_hazard_ctrl.md
Name: execute_hazard_ctrl

Overview:
- Pipeline sequencer for the Execute stage and the data-memory port.
- Decides per cycle which stages hold, which get bubbles/flushes, and when a resolved jump redirects fetch.
- Covers load-use interlock, data-memory request/response wait, and multi-cycle redirect flush after a taken jump/branch.
- Keeps stall and flush performance counters.

Parameters:
- FLUSH_CYCLES, 2, cycles the ID slot is flushed after a taken jump (covers synchronous IMEM latency); legal range 1..7.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_reg_we, ex_is_load  in  1  EX instruction writes rd / is a load
- do_jump  in  1  EX resolved a taken jump/branch
- mem_req_valid  in  1  MEM-stage instruction issues a DMEM access
- mem_req_is_load  in  1  that access returns data
- mem_req_ready  in  1  DMEM accepts the request this cycle
- mem_resp_valid  in  1  DMEM load data valid this cycle
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the stage register
- bubble_ex  out  1  load a NOP into EX
- flush_id  out  1  replace the ID instruction with a NOP
- redirect  out  1  fetch selects the jump target this cycle
- state_o  out  2  current FSM state (debug)
- stall_count, flush_count  out  CNT_W  performance counters

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state RUN, flush counter 0, both perf counters 0.
- All outputs are combinational from state and inputs. With RUN and idle inputs, every output is 0.

States:
- RUN=0, REQ_WAIT=1, RESP_WAIT=2, REDIRECT=3.

mem_freeze:
- Asserted when (RUN or REDIRECT) and mem_req_valid and !mem_req_ready.
- Asserted in REQ_WAIT when !mem_req_ready.
- Asserted in RESP_WAIT when !mem_resp_valid.
- While asserted: all four stall_* = 1; bubble_ex = 0, flush_id = 0, redirect = 0.
- do_jump and load-use detection are ignored; EX is held, so the jump is re-seen once the freeze clears.

Load-use:
- Condition: ex_is_load and ex_reg_we and ex_rd != 0, and ((id_uses_rs1 and id_rs1 == ex_rd) or (id_uses_rs2 and id_rs2 == ex_rd)).
- Action: stall_if = stall_id = 1 and bubble_ex = 1 for exactly one cycle. The next cycle the load is in MEM, so the condition self-clears.

Priority:
- Order is mem_freeze > do_jump > load-use.
- Jump and load-use in the same cycle: the jump wins. redirect = 1, flush_id = 1, no bubble.

Jump:
- In RUN, do_jump and no mem_freeze → redirect = 1, flush_id = 1 this cycle.
- If FLUSH_CYCLES > 1: load the flush counter with FLUSH_CYCLES-1 and go to REDIRECT.

REDIRECT:
- flush_id = 1 each non-frozen cycle; the counter decrements on each such cycle.
- Return to RUN when the counter reaches 0 (i.e. on the cycle it reads 1).
- Frozen cycles do not decrement the counter.
- A new do_jump in REDIRECT is not possible: EX holds a flushed NOP. If asserted anyway, ignore it.

Memory transitions:
- RUN/REDIRECT with mem_req_valid and !ready → REQ_WAIT. The REDIRECT counter is kept, and REDIRECT resumes afterwards (a saved return-state bit selects this).
- REQ_WAIT with ready and is_load → RESP_WAIT; with ready and !is_load → return state.
- Any state with an accepted load request (valid and ready and is_load) → RESP_WAIT.
- RESP_WAIT with mem_resp_valid → return state. A new request that same cycle is evaluated with RUN rules.

Counters:
- stall_count increments on every cycle with stall_if = 1.
- flush_count increments on every cycle with flush_id = 1.
- Both wrap modulo 2^CNT_W.

Reset mid-operation: any state returns to RUN immediately. Counters clear and the return-state bit clears.

Test Plan:
- Load x5 in EX, ID reads rs2=5 with id_uses_rs2=1 → one cycle of stall_if = stall_id = bubble_ex = 1, then all 0. Same with ex_rd=0 → no stall.
- do_jump pulse in RUN, FLUSH_CYCLES=2 → cycle0: redirect = flush_id = 1; cycle1: flush_id = 1; cycle2: RUN, outputs 0; flush_count = 2.
- Load-use and do_jump in the same cycle → redirect = 1, flush_id = 1, bubble_ex = 0.
- Store with mem_req_ready low for 3 cycles → state REQ_WAIT, all stalls = 1 for 3 cycles; back to RUN on the ready cycle; stall_count = 3.
- Load accepted, mem_resp_valid delayed 2 cycles, do_jump held high throughout → stalls for 2 cycles with redirect = 0, then redirect = 1 on the first unfrozen cycle.
- Assert rst_n = 0 asynchronously while in REDIRECT with counter 1 → state_o = 0 immediately; counters read 0; flush_id = 0 after release.
